branch_hazard_ctrl: RTL and testbench
=====================================

// Module: branch_hazard_ctrl
// PURPOSE
//  Sequences ID-stage branch resolution around the branch comparator (blez/beq/bne/bgez/bgtz/bltz).
//  Detects RAW hazards on branch source registers against EX/MEM producers and stalls IF/ID until
//  the operands are forwardable. Then samples BranchFlag and drives PC select and IF/ID flush.
//  Keeps saturating branch/taken/stall statistics counters.
// PARAMETERS
//  CNT_W     32  width of each statistics counter
//  REG_AW    5   register index width
// PORTS
//  Clk          in   1       rising-edge clock
//  Reset        in   1       asynchronous, active-low; 0 = reset
//  ID_Branch    in   1       ID-stage instruction is a conditional branch
//  ID_AluOp     in   4       branch op: 1010 blez,1011 beq,1100 bne,1101 bgez,1110 bgtz,1111 bltz
//  ID_Rs        in   REG_AW  branch source rs
//  ID_Rt        in   REG_AW  branch source rt (used only by beq/bne)
//  EX_RegWrite  in   1       EX-stage instruction writes a register
//  EX_MemRead   in   1       EX-stage instruction is a load
//  EX_Rd        in   REG_AW  EX-stage destination
//  MEM_RegWrite in   1       MEM-stage instruction writes a register
//  MEM_MemRead  in   1       MEM-stage instruction is a load
//  MEM_Rd       in   REG_AW  MEM-stage destination
//  BranchFlag   in   1       comparator result on forwarded operands (valid when not stalled)
//  Kill         in   1       older redirect (jump/exception); abandons the current branch
//  Stall        out  1       hold PC and IF/ID, insert bubble into ID/EX
//  PCSrc        out  1       1 = select branch target this cycle
//  FlushIFID    out  1       1 = squash the instruction in IF/ID this cycle
//  BranchCnt    out  CNT_W   branches resolved
//  TakenCnt     out  CNT_W   branches resolved taken
//  StallCnt     out  CNT_W   cycles Stall was asserted
// BEHAVIOUR
//  Hazard terms: UsesRt = (ID_AluOp==1011 | ID_AluOp==1100). Match(x) = x!=0 & (x==ID_Rs | UsesRt & x==ID_Rt).
//   hzEXld  = EX_RegWrite & EX_MemRead & Match(EX_Rd)           -> N=2
//   hzEXalu = EX_RegWrite & ~EX_MemRead & Match(EX_Rd)          -> N=1
//   hzMEMld = MEM_RegWrite & MEM_MemRead & Match(MEM_Rd)        -> N=1
//   none of the above                                           -> N=0 (hzEXld has priority)
//  States: IDLE, WAIT, RESOLVE. Cnt is 2 bits.
//  IDLE: if ID_Branch & ~Kill:
//   N=0 -> resolve now: PCSrc=FlushIFID=BranchFlag, Stall=0; BranchCnt++, TakenCnt+=BranchFlag; stay IDLE.
//   N>0 -> Stall=1; Cnt<=N-1; next = (N==1) ? RESOLVE : WAIT.
//   otherwise all outputs 0.
//  WAIT: Stall=1; Cnt<=Cnt-1; next=RESOLVE when Cnt==1. No hazard re-evaluation (ID is held).
//  RESOLVE: Stall=0; PCSrc=FlushIFID=BranchFlag; counters update as in IDLE; next IDLE.
//   A new branch is not accepted in the RESOLVE cycle (the ID instruction is the one resolving).
//  Kill in any state: outputs 0 that cycle, no counter update, next IDLE. Kill wins over a same-cycle branch.
//  StallCnt++ every cycle Stall=1. All counters saturate at 2^CNT_W-1 (no wrap).
//  Reset low (async): state IDLE, Cnt=0, counters 0. Stall/PCSrc/FlushIFID are forced 0 while Reset=0,
//   including mid-WAIT. First valid branch is possible on the first edge after Reset deasserts.
//  Latency: no hazard 0 cycles; ALU or MEM-load hazard 1 stall; EX-load hazard 2 stalls.
//  Rs/Rt == 0 never hazards. Non-branch ID_AluOp values with ID_Branch=1 are treated as rs-only.
// TESTING
//  beq r1,r2 with no producers, BranchFlag=1 -> same cycle PCSrc=1, FlushIFID=1, Stall=0; Branch/TakenCnt=1.
//  bne r3,r4 with EX add->r4 -> Stall=1 for 1 cycle, then RESOLVE with BranchFlag=0: PCSrc=0; StallCnt=1.
//  bgtz r5 with EX lw->r5 -> Stall=1 for 2 cycles, then PCSrc=1 with BranchFlag=1; StallCnt=2.
//  blez r6 with EX add->r7 (rt-only match, unused) -> no stall; EX_Rd=0 match -> no stall.
//  Kill during WAIT -> Stall drops the same cycle, next state IDLE, BranchCnt unchanged.
//  Reset pulsed low mid-WAIT -> outputs 0 immediately, counters 0; CNT_W=4 at 15 taken -> stays 15.

Source files
------------

// File: rtl/branch_hazard_ctrl_if.sv
// Branch hazard controller bundle.
// Groups the ID/EX/MEM hazard inputs, the comparator result and the redirect
// outputs of branch_hazard_ctrl so the pipeline can hand them over as one port.
//   master : pipeline side (drives ID/EX/MEM fields, BranchFlag, Kill; reads results)
//   slave  : controller side (reads hazard inputs; drives Stall/PCSrc/FlushIFID and counters)
interface branch_hazard_ctrl_if #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
);
  logic              ID_Branch;
  logic [3:0]        ID_AluOp;
  logic [REG_AW-1:0] ID_Rs;
  logic [REG_AW-1:0] ID_Rt;
  logic              EX_RegWrite;
  logic              EX_MemRead;
  logic [REG_AW-1:0] EX_Rd;
  logic              MEM_RegWrite;
  logic              MEM_MemRead;
  logic [REG_AW-1:0] MEM_Rd;
  logic              BranchFlag;
  logic              Kill;
  logic              Stall;
  logic              PCSrc;
  logic              FlushIFID;
  logic [CNT_W-1:0]  BranchCnt;
  logic [CNT_W-1:0]  TakenCnt;
  logic [CNT_W-1:0]  StallCnt;

  modport master (
    output ID_Branch, ID_AluOp, ID_Rs, ID_Rt,
    output EX_RegWrite, EX_MemRead, EX_Rd,
    output MEM_RegWrite, MEM_MemRead, MEM_Rd,
    output BranchFlag, Kill,
    input  Stall, PCSrc, FlushIFID, BranchCnt, TakenCnt, StallCnt
  );

  modport slave (
    input  ID_Branch, ID_AluOp, ID_Rs, ID_Rt,
    input  EX_RegWrite, EX_MemRead, EX_Rd,
    input  MEM_RegWrite, MEM_MemRead, MEM_Rd,
    input  BranchFlag, Kill,
    output Stall, PCSrc, FlushIFID, BranchCnt, TakenCnt, StallCnt
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch resolution sequencer.
// Detects RAW hazards between the branch sources and EX/MEM producers, stalls
// IF/ID until the operands can be forwarded, then samples BranchFlag to drive
// the PC select and IF/ID flush. Keeps saturating branch/taken/stall counters.
// Ports:
//   Clk   : rising-edge clock
//   Reset : asynchronous active-low reset
//   bus   : branch_hazard_ctrl_if.slave (hazard inputs, BranchFlag, Kill,
//           Stall/PCSrc/FlushIFID and the three statistics counters)
module branch_hazard_ctrl #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
) (
  input logic                 Clk,
  input logic                 Reset,
  branch_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t           state, nextState;
  logic [1:0]       cnt, nextCnt;
  logic             usesRt;
  logic             hzExLd, hzExAlu, hzMemLd;
  logic [1:0]       hzN;
  logic             stall, resolve;
  logic [CNT_W-1:0] branchCnt, takenCnt, stallCnt;

  // Register 0 is hard-wired and never a real producer.
  function automatic logic regMatch(input logic [REG_AW-1:0] x,
                                    input logic [REG_AW-1:0] rs,
                                    input logic [REG_AW-1:0] rt,
                                    input logic              useRt);
    return (x != '0) && ((x == rs) || (useRt && (x == rt)));
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Only beq/bne compare two registers; every other op is rs-only.
  always_comb begin
    usesRt  = (bus.ID_AluOp == 4'b1011) || (bus.ID_AluOp == 4'b1100);
    hzExLd  = bus.EX_RegWrite && bus.EX_MemRead &&
              regMatch(bus.EX_Rd, bus.ID_Rs, bus.ID_Rt, usesRt);
    hzExAlu = bus.EX_RegWrite && !bus.EX_MemRead &&
              regMatch(bus.EX_Rd, bus.ID_Rs, bus.ID_Rt, usesRt);
    hzMemLd = bus.MEM_RegWrite && bus.MEM_MemRead &&
              regMatch(bus.MEM_Rd, bus.ID_Rs, bus.ID_Rt, usesRt);
    if (hzExLd)                 hzN = 2'd2;
    else if (hzExAlu || hzMemLd) hzN = 2'd1;
    else                        hzN = 2'd0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // WAIT does not re-evaluate hazards: ID is frozen, so the stall length is
  // fixed when the branch is first seen in IDLE.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    if (bus.Kill) begin
      nextState = IDLE;
      nextCnt   = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ID_Branch && (hzN != 2'd0)) begin
            nextCnt   = hzN - 2'd1;
            nextState = (hzN == 2'd1) ? RESOLVE : WAIT;
          end
        end
        WAIT: begin
          nextCnt = cnt - 2'd1;
          if (cnt == 2'd1) nextState = RESOLVE;
        end
        RESOLVE: nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // Outputs are gated by Reset so they drop immediately on an async reset,
  // even in the middle of a stall.
  always_comb begin
    stall   = 1'b0;
    resolve = 1'b0;
    if (Reset && !bus.Kill) begin
      case (state)
        IDLE: begin
          if (bus.ID_Branch) begin
            if (hzN == 2'd0) resolve = 1'b1;
            else             stall   = 1'b1;
          end
        end
        WAIT:    stall   = 1'b1;
        RESOLVE: resolve = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      branchCnt <= '0;
      takenCnt  <= '0;
      stallCnt  <= '0;
    end else begin
      if (resolve)                   branchCnt <= satInc(branchCnt);
      if (resolve && bus.BranchFlag) takenCnt  <= satInc(takenCnt);
      if (stall)                     stallCnt  <= satInc(stallCnt);
    end
  end

  assign bus.Stall     = stall;
  assign bus.PCSrc     = resolve && bus.BranchFlag;
  assign bus.FlushIFID = resolve && bus.BranchFlag;
  assign bus.BranchCnt = branchCnt;
  assign bus.TakenCnt  = takenCnt;
  assign bus.StallCnt  = stallCnt;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: one wide-counter and one 4-bit-counter instance
// share the same stimulus and are compared against a cycle-count reference model.
module tb_branch_hazard_ctrl;
  localparam int REG_AW = 5;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  // driven stimulus
  logic              idBranch, exRegWrite, exMemRead, memRegWrite, memMemRead;
  logic              branchFlag, kill;
  logic [3:0]        idAluOp;
  logic [REG_AW-1:0] idRs, idRt, exRd, memRd;

  // staged stimulus, applied at the next falling edge
  logic              sReset, sBranch, sExW, sExR, sMemW, sMemR, sFlag, sKill;
  logic [3:0]        sOp;
  logic [REG_AW-1:0] sRs, sRt, sExRd, sMemRd;

  branch_hazard_ctrl_if #(.CNT_W(32), .REG_AW(REG_AW)) bus32 ();
  branch_hazard_ctrl_if #(.CNT_W(4),  .REG_AW(REG_AW)) bus4 ();

  assign bus32.ID_Branch = idBranch;     assign bus4.ID_Branch = idBranch;
  assign bus32.ID_AluOp = idAluOp;       assign bus4.ID_AluOp = idAluOp;
  assign bus32.ID_Rs = idRs;             assign bus4.ID_Rs = idRs;
  assign bus32.ID_Rt = idRt;             assign bus4.ID_Rt = idRt;
  assign bus32.EX_RegWrite = exRegWrite; assign bus4.EX_RegWrite = exRegWrite;
  assign bus32.EX_MemRead = exMemRead;   assign bus4.EX_MemRead = exMemRead;
  assign bus32.EX_Rd = exRd;             assign bus4.EX_Rd = exRd;
  assign bus32.MEM_RegWrite = memRegWrite; assign bus4.MEM_RegWrite = memRegWrite;
  assign bus32.MEM_MemRead = memMemRead; assign bus4.MEM_MemRead = memMemRead;
  assign bus32.MEM_Rd = memRd;           assign bus4.MEM_Rd = memRd;
  assign bus32.BranchFlag = branchFlag;  assign bus4.BranchFlag = branchFlag;
  assign bus32.Kill = kill;              assign bus4.Kill = kill;

  branch_hazard_ctrl #(.CNT_W(32), .REG_AW(REG_AW)) dut32 (.Clk(Clk), .Reset(Reset), .bus(bus32));
  branch_hazard_ctrl #(.CNT_W(4),  .REG_AW(REG_AW)) dut4  (.Clk(Clk), .Reset(Reset), .bus(bus4));

  int     vectors = 0;
  int     miscompares = 0;
  // reference model: remaining stall cycles of the branch in flight (-1 = none)
  int     pending = -1;
  longint mBranch = 0, mTaken = 0, mStall = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint satLim(input longint v, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  // number of stall cycles the branch needs before operands are forwardable
  function automatic int stallsNeeded(input int op, input int rs, input int rt,
                                      input bit exW, input bit exR, input int exRdV,
                                      input bit memW, input bit memR, input int memRdV);
    bit useRt, exHit, memHit;
    useRt  = (op == 11) || (op == 12);
    exHit  = (exRdV != 0) && ((exRdV == rs) || (useRt && exRdV == rt));
    memHit = (memRdV != 0) && ((memRdV == rs) || (useRt && memRdV == rt));
    if (exW && exR && exHit) return 2;
    if ((exW && !exR && exHit) || (memW && memR && memHit)) return 1;
    return 0;
  endfunction

  task automatic cycle();
    bit eStall, eRes;
    int nextPending, n;
    @(negedge Clk);
    Reset = sReset; idBranch = sBranch; idAluOp = sOp; idRs = sRs; idRt = sRt;
    exRegWrite = sExW; exMemRead = sExR; exRd = sExRd;
    memRegWrite = sMemW; memMemRead = sMemR; memRd = sMemRd;
    branchFlag = sFlag; kill = sKill;
    #1;
    eStall = 1'b0; eRes = 1'b0; nextPending = pending;
    if (!sReset) begin
      mBranch = 0; mTaken = 0; mStall = 0; nextPending = -1;
    end else if (sKill) begin
      nextPending = -1;
    end else if (pending > 0) begin
      eStall = 1'b1; nextPending = pending - 1;
    end else if (pending == 0) begin
      eRes = 1'b1; nextPending = -1;
    end else if (sBranch) begin
      n = stallsNeeded(int'(sOp), int'(sRs), int'(sRt), sExW, sExR, int'(sExRd),
                       sMemW, sMemR, int'(sMemRd));
      if (n == 0) eRes = 1'b1;
      else begin eStall = 1'b1; nextPending = n - 1; end
    end
    checkVal("Stall32", bus32.Stall, eStall);
    checkVal("PCSrc32", bus32.PCSrc, eRes && sFlag);
    checkVal("FlushIFID32", bus32.FlushIFID, eRes && sFlag);
    checkVal("Stall4", bus4.Stall, eStall);
    checkVal("PCSrc4", bus4.PCSrc, eRes && sFlag);
    checkVal("FlushIFID4", bus4.FlushIFID, eRes && sFlag);
    checkVal("BranchCnt32", bus32.BranchCnt, satLim(mBranch, 32));
    checkVal("TakenCnt32", bus32.TakenCnt, satLim(mTaken, 32));
    checkVal("StallCnt32", bus32.StallCnt, satLim(mStall, 32));
    checkVal("BranchCnt4", bus4.BranchCnt, satLim(mBranch, 4));
    checkVal("TakenCnt4", bus4.TakenCnt, satLim(mTaken, 4));
    checkVal("StallCnt4", bus4.StallCnt, satLim(mStall, 4));
    if (sReset) begin
      if (eStall) mStall++;
      if (eRes) begin mBranch++; if (sFlag) mTaken++; end
    end
    pending = nextPending;
  endtask

  task automatic quiet();
    sBranch = 0; sOp = 4'b0000; sRs = '0; sRt = '0; sExW = 0; sExR = 0; sExRd = '0;
    sMemW = 0; sMemR = 0; sMemRd = '0; sFlag = 0; sKill = 0;
  endtask

  initial begin
    Reset = 1'b0; idBranch = 0; idAluOp = '0; idRs = '0; idRt = '0;
    exRegWrite = 0; exMemRead = 0; exRd = '0; memRegWrite = 0; memMemRead = 0;
    memRd = '0; branchFlag = 0; kill = 0;
    quiet();
    sReset = 0; cycle(); cycle();
    sReset = 1;
    // beq r1,r2, no producers, taken
    sBranch = 1; sOp = 4'b1011; sRs = 5'd1; sRt = 5'd2; sFlag = 1; cycle();
    quiet(); cycle();
    // bne r3,r4 behind EX add->r4: one stall, then not-taken
    sBranch = 1; sOp = 4'b1100; sRs = 5'd3; sRt = 5'd4; sExW = 1; sExRd = 5'd4; cycle();
    sExW = 0; sFlag = 0; cycle();
    quiet(); cycle();
    // bgtz r5 behind EX lw->r5: two stalls, then taken
    sBranch = 1; sOp = 4'b1110; sRs = 5'd5; sExW = 1; sExR = 1; sExRd = 5'd5; sFlag = 1;
    cycle(); cycle(); cycle();
    quiet(); cycle();
    // blez r6 with rt-only match on r7, then a zero-register match
    sBranch = 1; sOp = 4'b1010; sRs = 5'd6; sRt = 5'd7; sExW = 1; sExRd = 5'd7; cycle();
    sRs = '0; sExRd = '0; sExR = 1; cycle();
    quiet(); cycle();
    // Kill during WAIT, then a fresh branch resolves immediately from IDLE
    sBranch = 1; sOp = 4'b1110; sRs = 5'd5; sExW = 1; sExR = 1; sExRd = 5'd5; cycle();
    sKill = 1; cycle();
    quiet(); sBranch = 1; sOp = 4'b1101; sRs = 5'd9; sFlag = 1; cycle();
    // Kill beats a same-cycle branch
    sKill = 1; cycle();
    quiet(); cycle();
    // Reset pulsed mid-WAIT
    sBranch = 1; sOp = 4'b1111; sRs = 5'd8; sExW = 1; sExR = 1; sExRd = 5'd8; cycle();
    sReset = 0; cycle();
    sReset = 1; quiet(); cycle();
    // saturation of the 4-bit counters: 18 taken branches, then stalls
    sBranch = 1; sOp = 4'b1011; sRs = 5'd1; sRt = 5'd2; sFlag = 1;
    for (int i = 0; i < 18; i++) cycle();
    sExW = 1; sExR = 1; sExRd = 5'd1;
    for (int i = 0; i < 24; i++) cycle();
    quiet(); cycle();
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      sReset = ($urandom_range(0, 199) != 0);
      sBranch = $urandom_range(0, 1);
      sOp = 4'($urandom_range(9, 15));
      sRs = 5'($urandom_range(0, 7)); sRt = 5'($urandom_range(0, 7));
      sExW = $urandom_range(0, 1); sExR = $urandom_range(0, 1); sExRd = 5'($urandom_range(0, 7));
      sMemW = $urandom_range(0, 1); sMemR = $urandom_range(0, 1); sMemRd = 5'($urandom_range(0, 7));
      sFlag = $urandom_range(0, 1);
      sKill = ($urandom_range(0, 15) == 0);
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
